mul_nibble_seq: RTL and testbench

//  Multi-cycle unsigned WxW multiplier. One shared 4x4 combinational array multiplier
//  (HA/FA reduction tree plus final adder) is time-multiplexed across all nibble pairs.

---
 rtl/mul_seq_pkg.sv | 11 +
 rtl/mul4x4_core.sv | 40 ++++
 rtl/mul_nibble_seq.sv | 86 ++++++++
 tb/tb_mul_nibble_seq.sv | 114 +++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and sizing helpers for the nibble-serial multiplier
//   state_t : FSM encoding (IDLE, BUSY, DONE)
//   NIB     : slice width handled by the shared 4x4 core
//   np(w)   : number of nibble products per w x w operation
package mul_seq_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam int NIB = 4;
   function automatic int np(input int w);
      return (w / NIB) * (w / NIB);
   endfunction
endpackage

// File: rtl/mul4x4_core.sv
// mul4x4_core: combinational 4x4 unsigned array multiplier built from HA/FA cells
//   x [3:0] : multiplicand nibble
//   y [3:0] : multiplier nibble
//   o [7:0] : product x*y
module mul4x4_core (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [7:0] o
);
   logic [4:0] p;
   logic [4:0] s;
   logic       c;
   logic       a;
   logic       b;
   // Each row ripples the next partial-product row into the upper bits of the
   // running sum; bit 0 of every row is final. The column-0 cell sees c=0 (a HA),
   // the rest are FAs, and the last row's upper bits form the final adder output.
   always_comb begin
      o = '0;
      s = '0;
      c = 1'b0;
      a = 1'b0;
      b = 1'b0;
      p = {1'b0, x & {4{y[0]}}};
      o[0] = p[0];
      for (int r = 1; r < 4; r++) begin
         c = 1'b0;
         for (int k = 0; k < 4; k++) begin
            a = x[k] & y[r];
            b = p[k+1];
            s[k] = a ^ b ^ c;
            c = (a & b) | (c & (a ^ b));
         end
         s[4] = c;
         p = s;
         o[r] = p[0];
      end
      o[7:4] = p[4:1];
   end
endmodule

// File: rtl/mul_nibble_seq.sv
// mul_nibble_seq: multi-cycle unsigned WxW multiplier reusing one 4x4 core per nibble pair
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake, in_a/in_b latched on acceptance
//   out_valid/out_ready  : product handshake, out_p held until taken and afterwards
//   busy                 : high while nibble products are being accumulated
//   MUL_ZERO_SKIP_EN     : when defined, a zero operand goes straight to DONE with out_p=0
module mul_nibble_seq
   import mul_seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_p,
   output logic           busy
);
   localparam int NPP = np(W);
   localparam int NW  = W / NIB;
   localparam int IW  = NPP > 1 ? $clog2(NPP) : 1;
   localparam int PW  = 2 * W;
   state_t          state;
   state_t          state_nxt;
   logic [W-1:0]    a_r;
   logic [W-1:0]    b_r;
   logic [PW-1:0]   acc;
   logic [PW-1:0]   acc_nxt;
   logic [IW-1:0]   idx;
   logic [NIB-1:0]  xa;
   logic [NIB-1:0]  yb;
   logic [7:0]      prod;
   logic            last;
   logic            zero;
   int              i;
   int              j;
`ifdef MUL_ZERO_SKIP_EN
   assign zero = (in_a == '0) || (in_b == '0);
`else
   assign zero = 1'b0;
`endif
   assign i         = int'(idx) % NW;
   assign j         = int'(idx) / NW;
   assign xa        = a_r[NIB*i +: NIB];
   assign yb        = b_r[NIB*j +: NIB];
   assign last      = idx == IW'(NPP - 1);
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign busy      = state == BUSY;
   mul4x4_core u_core (.x(xa), .y(yb), .o(prod));
   always_comb begin
      acc_nxt = acc + (PW'(prod) << (NIB * (i + j)));
   end
   always_comb begin
      state_nxt = state == IDLE ? (in_valid ? (zero ? DONE : BUSY) : IDLE)
                : state == BUSY ? (last ? DONE : BUSY)
                : (out_ready ? IDLE : DONE);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         acc   <= '0;
         idx   <= '0;
         out_p <= '0;
      end else if (state == IDLE && in_valid) begin
         a_r <= in_a;
         b_r <= in_b;
         acc <= '0;
         idx <= '0;
         if (zero) out_p <= '0;
      end else if (state == BUSY) begin
         acc <= acc_nxt;
         idx <= idx + 1'b1;
         if (last) out_p <= acc_nxt;
      end
   end
endmodule

// File: tb/tb_mul_nibble_seq.sv
// tb_mul_nibble_seq: directed self-checking bench for mul_nibble_seq at W=8
module tb_mul_nibble_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_p;
   logic        busy;
   int          checks = 0;
   int          errors = 0;
`ifdef MUL_ZERO_SKIP_EN
   localparam int ZLAT = 0;
`else
   localparam int ZLAT = 4;
`endif
   mul_nibble_seq #(.W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_p(out_p), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                      input int lat, input bit poke, input int hold);
      int k;
      chk("in_ready_idle", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      tick;
      in_valid = poke;
      in_a = ~a;
      in_b = ~b;
      k = 0;
      while (!out_valid && k < 50) begin
         chk("in_ready_busy", 32'(in_ready), 0);
         chk("busy_high", 32'(busy), 1);
         tick;
         k++;
      end
      chk("latency", k, lat);
      chk("out_p", 32'(out_p), 32'(exp));
      chk("busy_done", 32'(busy), 0);
      chk("in_ready_done", 32'(in_ready), 0);
      for (int h = 0; h < hold; h++) begin
         tick;
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_out_p", 32'(out_p), 32'(exp));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("in_ready_back", 32'(in_ready), 1);
      chk("out_valid_back", 32'(out_valid), 0);
      chk("out_p_kept", 32'(out_p), 32'(exp));
   endtask
   initial begin
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out_p", 32'(out_p), 0);
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      run(8'd200, 8'd150, 16'd30000, 4, 1'b0, 0);
      run(8'd255, 8'd255, 16'd65025, 4, 1'b1, 0);
      run(8'h12,  8'h34,  16'h03A8,  4, 1'b0, 3);
      run(8'hF0,  8'h0F,  16'h0E10,  4, 1'b0, 0);
      run(8'd16,  8'd16,  16'd256,   4, 1'b0, 0);
      run(8'd255, 8'd1,   16'd255,   4, 1'b0, 0);
      in_valid = 1'b1;
      in_a = 8'd7;
      in_b = 8'd9;
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      chk("pre_rst_busy", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 32'(in_ready), 1);
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_out_p", 32'(out_p), 0);
      tick;
      #2;
      rst_n = 1'b1;
      tick;
      chk("post_rst_idle", 32'(out_valid), 0);
      run(8'd3,   8'd5,   16'd15,    4, 1'b0, 0);
      run(8'd0,   8'd123, 16'd0,     ZLAT, 1'b0, 0);
      run(8'd77,  8'd0,   16'd0,     ZLAT, 1'b0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
